// File: rtl/sbmips_pkg.sv
// Shared sbmips definitions: reset vector, NOP encoding, fetch FSM states and the
// (pc, inst) pair carried between fetch and decode.
package sbmips_pkg;

    localparam logic [29:0] RESET_VECTOR_DEF = 30'h2FF00000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_REQ   = 2'd0;
    localparam fetch_state_t ST_HOLD  = 2'd1;
    localparam fetch_state_t ST_DRAIN = 2'd2;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] inst;
    } fetch_pair_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry (pc, inst) buffer that parks a fetch completing while decode is stalled.
// clear wins over load; unload only drops the full flag.
module fetch_hold_buf
    import sbmips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  fetch_pair_t din,
    output fetch_pair_t dout,
    output logic        full
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            dout <= '{pc: 30'h0, inst: NOP};
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            dout <= din;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// sbmips instruction fetch: PC sequencing, imem req/ack, stall hold and redirect flush.
// Define IFETCH_PERF_CNT_EN to add the perf_fetched / perf_stall_cycles counters.
module inst_fetch
    import sbmips_pkg::*;
#(
    parameter logic [29:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [29:0] redirect_pc,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        valid,
    output logic [29:0] pc_out,
    output logic [31:0] inst_out
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cycles
`endif
);

    fetch_state_t state;
    logic [29:0]  target;
    logic         slot_free;
    logic         hb_load, hb_unload, hb_clear, hb_full;
    fetch_pair_t  hb_dout;

    assign imem_req  = (state != ST_HOLD);
    assign slot_free = !valid || !stall;

    always_comb begin
        hb_load   = 1'b0;
        hb_unload = 1'b0;
        hb_clear  = redirect;
        if (!redirect) begin
            hb_load   = (state == ST_REQ) && imem_ack && !slot_free;
            hb_unload = (state == ST_HOLD) && !stall;
        end
    end

    fetch_hold_buf u_hold (
        .clk    (clk),
        .rst    (rst),
        .load   (hb_load),
        .unload (hb_unload),
        .clear  (hb_clear),
        .din    ('{pc: imem_addr, inst: imem_rdata}),
        .dout   (hb_dout),
        .full   (hb_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_REQ;
            imem_addr <= RESET_VECTOR;
            target    <= RESET_VECTOR;
            valid     <= 1'b0;
            pc_out    <= 30'h0;
            inst_out  <= NOP;
        end else begin
            case (state)
                ST_REQ: begin
                    if (redirect) begin
                        valid <= 1'b0;
                        if (imem_ack) begin
                            imem_addr <= redirect_pc;
                        end else begin
                            // request still in flight: address must stay put until ack
                            target <= redirect_pc;
                            state  <= ST_DRAIN;
                        end
                    end else if (imem_ack) begin
                        imem_addr <= imem_addr + 30'd1;
                        if (slot_free) begin
                            pc_out   <= imem_addr;
                            inst_out <= imem_rdata;
                            valid    <= 1'b1;
                        end else begin
                            state <= ST_HOLD;
                        end
                    end else if (valid && !stall) begin
                        valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        valid     <= 1'b0;
                        imem_addr <= redirect_pc;
                        state     <= ST_REQ;
                    end else if (!stall && hb_full) begin
                        pc_out   <= hb_dout.pc;
                        inst_out <= hb_dout.inst;
                        valid    <= 1'b1;
                        state    <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (redirect) begin
                        valid  <= 1'b0;
                        target <= redirect_pc;
                    end
                    if (imem_ack) begin
                        imem_addr <= redirect ? redirect_pc : target;
                        state     <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched      <= 32'h0;
            perf_stall_cycles <= 32'h0;
        end else begin
            if (valid && !stall) perf_fetched      <= perf_fetched + 32'd1;
            if (valid && stall)  perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed vectors push expected (pc, inst) handoffs,
// a negedge monitor pops and compares on every valid && !stall.
module tb_inst_fetch;

    localparam logic [29:0] RV = 30'h2FF00000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [29:0] redirect_pc = 30'h0;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        valid;
    logic [29:0] pc_out;
    logic [31:0] inst_out;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall_cycles;
`endif

    // memory model: acks after ws idle cycles when enabled, data derived from address
    logic       mem_en = 1'b0;
    logic [3:0] ws = 4'd0;
    logic [3:0] wcnt;

    int npass = 0;
    int ntot  = 0;
    logic [29:0] sb[$];

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .valid       (valid),
        .pc_out      (pc_out),
        .inst_out    (inst_out)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetched      (perf_fetched),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    assign imem_ack   = !rst && imem_req && mem_en && (wcnt >= ws);
    assign imem_rdata = {imem_addr, 2'b11};

    always @(posedge clk or posedge rst) begin
        if (rst)                       wcnt <= 4'd0;
        else if (!imem_req || imem_ack) wcnt <= 4'd0;
        else if (mem_en)               wcnt <= wcnt + 4'd1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && valid && !stall) begin
            if (sb.size() == 0) begin
                ntot++;
                $display("FAIL sb_unexpected: got pc %h with nothing expected", pc_out);
            end else begin
                logic [29:0] e;
                e = sb.pop_front();
                chk("sb_pc", {2'b00, pc_out}, {2'b00, e});
                chk("sb_inst", inst_out, {e, 2'b11});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        @(negedge clk); @(negedge clk);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_pc_out", {2'b00, pc_out}, 32'h0);
        chk("rst_inst_out", inst_out, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h1);
        chk("rst_addr", {2'b00, imem_addr}, {2'b00, RV});

        // zero-wait streaming from the reset vector
        @(posedge clk); #1;
        rst = 1'b0;
        mem_en = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back(RV + 30'(i));
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stream_valid", {31'h0, valid}, 32'h1);
        end
        mem_en = 1'b0;
        cyc();

        // 3-cycle stall while an ack lands in the hold buffer
        sb.push_back(RV + 30'd3);
        sb.push_back(RV + 30'd4);
        mem_en = 1'b1;
        cyc();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_req", {31'h0, imem_req}, 32'h0);
            chk("hold_pc_frozen", {2'b00, pc_out}, {2'b00, RV + 30'd3});
        end
        stall = 1'b0;
        mem_en = 1'b0;
        cyc();
        chk("hold_delivered", {2'b00, pc_out}, {2'b00, RV + 30'd4});
        cyc();

        // redirect mid-request with a 2 wait-state memory
        sb.push_back(30'h100);
        ws = 4'd2;
        mem_en = 1'b1;
        cyc();
        redirect = 1'b1;
        redirect_pc = 30'h100;
        cyc();
        redirect = 1'b0;
        chk("drain_addr_stable", {2'b00, imem_addr}, {2'b00, RV + 30'd5});
        chk("drain_valid", {31'h0, valid}, 32'h0);
        chk("drain_req", {31'h0, imem_req}, 32'h1);
        cyc();
        chk("drain_addr_target", {2'b00, imem_addr}, 32'h100);
        chk("drain_valid2", {31'h0, valid}, 32'h0);
        ws = 4'd0;
        cyc();
        mem_en = 1'b0;
        cyc();

        // redirect in the same cycle as an ack while stalled
        sb.push_back(30'h200);
        mem_en = 1'b1;
        cyc();
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 30'h200;
        cyc();
        chk("redir_ack_valid", {31'h0, valid}, 32'h0);
        chk("redir_ack_addr", {2'b00, imem_addr}, 32'h200);
        chk("redir_ack_req", {31'h0, imem_req}, 32'h1);
        redirect = 1'b0;
        stall = 1'b0;
        cyc();
        mem_en = 1'b0;
        cyc();

        // redirect while in HOLD
        sb.push_back(30'h300);
        mem_en = 1'b1;
        cyc();
        stall = 1'b1;
        cyc();
        chk("hold2_req", {31'h0, imem_req}, 32'h0);
        redirect = 1'b1;
        redirect_pc = 30'h300;
        cyc();
        chk("redir_hold_valid", {31'h0, valid}, 32'h0);
        chk("redir_hold_addr", {2'b00, imem_addr}, 32'h300);
        redirect = 1'b0;
        stall = 1'b0;
        cyc();
        mem_en = 1'b0;
        cyc();

        // address wrap at the top of the 30-bit space
        sb.push_back(30'h3FFFFFFF);
        sb.push_back(30'h0);
        mem_en = 1'b1;
        redirect = 1'b1;
        redirect_pc = 30'h3FFFFFFF;
        cyc();
        redirect = 1'b0;
        chk("wrap_redir_valid", {31'h0, valid}, 32'h0);
        chk("wrap_redir_addr", {2'b00, imem_addr}, 32'h3FFFFFFF);
        cyc();
        cyc();
        mem_en = 1'b0;
        cyc();
        chk("wrap_next_addr", {2'b00, imem_addr}, 32'h1);

`ifdef IFETCH_PERF_CNT_EN
        rst = 1'b1;
        cyc();
        chk("perf_rst_fetched", perf_fetched, 32'h0);
        chk("perf_rst_stall", perf_stall_cycles, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) sb.push_back(RV + 30'(i));
        mem_en = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        mem_en = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        stall = 1'b0;
        cyc();
        chk("perf_fetched", perf_fetched, 32'd10);
        chk("perf_stall_cycles", perf_stall_cycles, 32'd4);
        rst = 1'b1;
        cyc();
        chk("perf_clr_fetched", perf_fetched, 32'h0);
        chk("perf_clr_stall", perf_stall_cycles, 32'h0);
        rst = 1'b0;
`endif

        cyc();
        cyc();
        chk("sb_empty", sb.size(), 32'h0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the sbmips pipeline. It sequences the program counter, fetches words from instruction memory over a req/ack handshake, and presents one registered (pc, instruction) pair per cycle to the decode stage. It honours downstream stall and upstream PC redirect from branch/jump resolution. A one-entry hold buffer absorbs a fetch that completes while decode is stalled.

## Interface
Parameters:
- RESET_VECTOR, 30'h2FF00000 (byte address 0xBFC00000), first word address fetched after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  decode cannot accept; output pair must hold.
- redirect  in  1  single-cycle pulse: flush and continue fetching at redirect_pc.
- redirect_pc  in  30  word address [31:2] of the redirect target.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  30  word address of the request; stable while imem_req is high until imem_ack.
- imem_ack  in  1  memory completes the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- valid  out  1  pc_out/inst_out hold a live instruction.
- pc_out  out  30  word address of the delivered instruction.
- inst_out  out  32  delivered instruction word.

## Operation
- States: REQ (imem_req=1), HOLD (imem_req=0, hold buffer full), DRAIN (imem_req=1, result discarded).
- Reset values: state REQ, imem_addr=RESET_VECTOR, valid=0, pc_out=0, inst_out=32'h0 (NOP), hold buffer empty. imem_req is derived from state and is 1 immediately after reset.
- Handoff: decode accepts when valid && !stall. Output registers change only on acceptance, on a fill of an empty slot, or on flush.
- REQ, ack, slot free (valid=0, or stall=0): load pc_out=imem_addr, inst_out=imem_rdata, valid=1. imem_addr <= imem_addr+1. Stay in REQ.
- REQ, ack, valid && stall: write the word into the hold buffer, increment imem_addr, go to HOLD.
- REQ, no ack, slot free: valid <= 0 after any acceptance.
- HOLD, stall=0: move the hold buffer to the output (valid=1), empty the buffer, go to REQ.
- Redirect has top priority in every state, stall ignored: valid <= 0, hold buffer emptied, the target is stored.
  - If a request is outstanding and not acked this cycle: go to DRAIN, keeping imem_addr stable. On ack, discard the data, set imem_addr=target, go to REQ.
  - If acked in the redirect cycle, or in HOLD: discard the data, set imem_addr=redirect_pc, go to REQ.
  - A redirect during DRAIN overwrites the stored target.
- Address arithmetic: 30-bit, 30'h3FFFFFFF+1 wraps to 30'h0.

## Timing
- Zero-wait memory (ack in the request cycle): request at A in cycle n, valid with pc_out=A in n+1. Sustained throughput 1 instruction/cycle.
- Wait-state memory: delivery in the cycle after the ack.
- Redirect in cycle n, nothing outstanding: valid=0 and imem_addr=target in n+1, target delivered in n+2 (zero-wait).
- Stall: the output holds indefinitely. At most one extra word is buffered. No request is issued in HOLD.
- rst mid-transaction: immediate return to reset values. The memory must drop any pending ack on rst.

## Configuration
- IFETCH_PERF_CNT_EN defined: adds output ports perf_fetched[31:0] and perf_stall_cycles[31:0], both reset to 0 and wrapping.
  - perf_fetched increments on each handoff (valid && !stall).
  - perf_stall_cycles increments on each cycle with valid && stall.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package sbmips_pkg holds RESET_VECTOR default, the NOP encoding (32'h0), and the fetch state enum (REQ/HOLD/DRAIN).
- One sub-module, fetch_hold_buf: 1-entry (pc, inst) buffer with load/unload/clear and a full flag.

## Test plan
- Reset release, zero-wait memory returning addr-derived data: pc_out sequence 2FF00000, 2FF00001, 2FF00002 on consecutive cycles, valid=1 from cycle 2.
- stall held 3 cycles while ack arrives: output frozen, imem_req=0 in HOLD, buffered word delivered the cycle stall falls, with no word lost or duplicated.
- redirect to 30'h00000100 with 2 wait-state memory mid-request: imem_addr unchanged until ack, stale word never valid, next delivered pc_out=00000100.
- Redirect in the same cycle as ack while stalled: valid=0 next cycle, hold buffer empty, target fetched next.
- redirect_pc=30'h3FFFFFFF: delivers 3FFFFFFF then 00000000.
- With IFETCH_PERF_CNT_EN: 10 handoffs plus 4 stalled cycles give perf_fetched=10 and perf_stall_cycles=4. rst clears both.
